// File: rtl/router_pkg.sv
// Shared types and constants for the SPI packet router: FSM state encoding and
// frame-width helpers.
package router_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SETUP,
        SHIFT,
        HOLD,
        DONE,
        ERR
    } route_state_e;

    localparam int DEF_SIZE = 8;
    localparam int FRAME_W  = 2 * DEF_SIZE;

    // Frame is {destination, data}, so it is always twice the field width.
    function automatic int frame_bits(input int size);
        return 2 * size;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period timer: while i_run is high it emits a strobe at the end of
// every CLK_DIV-cycle half-period, split into rise/fall by the current phase.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_run,
    output logic o_en,
    output logic o_rise,
    output logic o_fall,
    output logic o_sclk
);

    localparam int              CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          w_tick;

    assign w_tick = i_run && (r_cnt == LAST);

    // Dropping i_run restarts the timer, so every frame begins in the low phase.
    always_ff @(posedge clock) begin
        if (reset || !i_run) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign o_en   = w_tick;
    assign o_rise = w_tick && !r_phase;
    assign o_fall = w_tick &&  r_phase;
    assign o_sclk = r_phase;

endmodule

// File: rtl/route_spi_tx.sv
// Routes one {destination, data} packet out as a mode-0 SPI frame on the chip
// select of the destination port. Define ROUTE_CHECKSUM_EN to reject packets
// whose checkSum does not match destination+data.
import router_pkg::*;

module route_spi_tx #(
    parameter int SIZE    = 8,
    parameter int PORTS   = 4,
    parameter int CLK_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [SIZE-1:0]  destination,
    input  logic [SIZE-1:0]  data,
    input  logic [SIZE:0]    checkSum,
    output logic             sclk,
    output logic             mosi,
    output logic [PORTS-1:0] cs_n,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int              FW        = frame_bits(SIZE);
    localparam int              HALVES    = 2 * FW;
    localparam int              HW        = $clog2(HALVES);
    localparam logic [HW-1:0]   HALF_LAST = HW'(HALVES - 1);
    localparam logic [SIZE:0]   PORTS_L   = (SIZE + 1)'(PORTS);

    route_state_e    r_state, w_next;
    logic [SIZE-1:0] r_dest, r_data;
    logic [SIZE:0]   r_chk;
    logic [FW-1:0]   r_shift;
    logic [HW-1:0]   r_half;

    logic            w_active;
    logic            w_half, w_rise, w_fall, w_sclk_ph;
    logic [SIZE:0]   w_sum;
    logic            w_bad_dest, w_bad_sum, w_reject;

    assign w_active = (r_state == SETUP) || (r_state == SHIFT) || (r_state == HOLD);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clock  (clock),
        .reset  (reset),
        .i_run  (w_active),
        .o_en   (w_half),
        .o_rise (w_rise),
        .o_fall (w_fall),
        .o_sclk (w_sclk_ph)
    );

    // Carry is kept in bit SIZE so it lines up with the (SIZE+1)-bit checkSum.
    assign w_sum      = {1'b0, r_dest} + {1'b0, r_data};
    assign w_bad_dest = {1'b0, r_dest} >= PORTS_L;
`ifdef ROUTE_CHECKSUM_EN
    assign w_bad_sum  = (w_sum != r_chk);
`else
    logic w_unused_chk;
    assign w_bad_sum    = 1'b0;
    assign w_unused_chk = ^{r_chk, w_sum};
`endif
    assign w_reject   = w_bad_dest || w_bad_sum;

    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != IDLE);
        done   = (r_state == DONE);
        error  = (r_state == ERR);
        sclk   = (r_state == SHIFT) && w_sclk_ph;
        mosi   = w_active && r_shift[FW-1];
        cs_n   = '1;
        for (int p = 0; p < PORTS; p++)
            cs_n[p] = !(w_active && (r_dest == SIZE'(p)));
        unique case (r_state)
            IDLE:      if (start) w_next = CHECK;
            CHECK:     w_next = w_reject ? ERR : SETUP;
            SETUP:     if (w_rise) w_next = SHIFT;
            SHIFT:     if (w_half && (r_half == HALF_LAST)) w_next = HOLD;
            HOLD:      if (w_half) w_next = DONE;
            DONE, ERR: w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // SETUP presents the MSB; each falling SCLK edge in SHIFT exposes the next bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dest  <= '0;
            r_data  <= '0;
            r_chk   <= '0;
            r_shift <= '0;
            r_half  <= '0;
        end else begin
            if ((r_state == IDLE) && start) begin
                r_dest <= destination;
                r_data <= data;
                r_chk  <= checkSum;
            end
            if (r_state == CHECK)
                r_shift <= {r_dest, r_data};
            else if ((r_state == SHIFT) && w_fall)
                r_shift <= {r_shift[FW-2:0], 1'b0};
            if (r_state != SHIFT)
                r_half <= '0;
            else if (w_half)
                r_half <= r_half + HW'(1);
        end
    end

endmodule

// File: tb/tb_route_spi_tx.sv
// Directed bench for route_spi_tx: table of packets plus hand-written
// sequences for start-while-busy, mid-frame reset and reset-vs-start.
module tb_route_spi_tx;

    localparam int LAT  = 2 + (4 * 8 + 2) * 4;
    localparam int NCYC = 150;

    logic       clock = 1'b0;
    logic       reset, start;
    logic [7:0] destination, data;
    logic [8:0] checkSum;
    logic       sclk, mosi, busy, done, error;
    logic [3:0] cs_n;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    route_spi_tx #(.SIZE(8), .PORTS(4), .CLK_DIV(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .destination (destination),
        .data        (data),
        .checkSum    (checkSum),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    typedef struct {
        string      name;
        logic [7:0] dest;
        logic [7:0] dat;
        logic [8:0] chk;
        bit         accept;
        logic [15:0] frame;
        logic [3:0] cs;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    // Send one packet (start in cycle N) and observe cycles N+1..N+NCYC.
    task automatic run(input logic [7:0] d, input logic [7:0] dt, input logic [8:0] c,
                       input int second_k, input int rst_k,
                       output int err_k, output int done_k, output int n_done, output int n_err,
                       output int rises, output int busy_first, output int busy_last,
                       output logic [15:0] frame, output logic [3:0] cs_seen);
        logic prev_sclk;
        err_k = -1; done_k = -1; n_done = 0; n_err = 0; rises = 0;
        busy_first = -1; busy_last = -1; frame = '0; cs_seen = '0; prev_sclk = 1'b0;
        @(negedge clock);
        start = 1'b1; destination = d; data = dt; checkSum = c;
        for (int k = 1; k <= NCYC; k++) begin
            @(negedge clock);
            start = (k == second_k);
            if (k == second_k) begin
                destination = 8'h01; data = 8'hAA; checkSum = 9'h0AB;
            end
            if (error) begin n_err++; if (err_k < 0) err_k = k; end
            if (done) begin n_done++; if (done_k < 0) done_k = k; end
            if (busy) begin if (busy_first < 0) busy_first = k; busy_last = k; end
            cs_seen = cs_seen | ~cs_n;
            if (sclk && !prev_sclk) begin
                rises++;
                frame = {frame[14:0], mosi};
            end
            prev_sclk = sclk;
            if (k == rst_k) reset = 1'b1;
            if (k == rst_k + 1) begin
                check("midframe_reset_cs_n", int'(cs_n), 15);
                check("midframe_reset_busy", int'(busy), 0);
                reset = 1'b0;
            end
        end
    endtask

    int ek, dk, nd, ne, nr, bf, bl;
    logic [15:0] fr;
    logic [3:0]  cs;

    initial begin
        vecs[0] = '{"nominal",     8'h02, 8'h35, 9'h037, 1'b1, 16'h0235, 4'b1011};
`ifdef ROUTE_CHECKSUM_EN
        vecs[1] = '{"bad_sum",     8'h02, 8'h35, 9'h036, 1'b0, 16'h0235, 4'b1011};
        vecs[7] = '{"bad_sum_b8",  8'h02, 8'h35, 9'h137, 1'b0, 16'h0235, 4'b1011};
`else
        vecs[1] = '{"bad_sum",     8'h02, 8'h35, 9'h036, 1'b1, 16'h0235, 4'b1011};
        vecs[7] = '{"bad_sum_b8",  8'h02, 8'h35, 9'h137, 1'b1, 16'h0235, 4'b1011};
`endif
        vecs[2] = '{"dest_5",      8'h05, 8'h35, 9'h03A, 1'b0, 16'h0535, 4'b1111};
        vecs[3] = '{"carry",       8'h03, 8'hFF, 9'h102, 1'b1, 16'h03FF, 4'b0111};
        vecs[4] = '{"zero",        8'h00, 8'h00, 9'h000, 1'b1, 16'h0000, 4'b1110};
        vecs[5] = '{"port1",       8'h01, 8'h80, 9'h081, 1'b1, 16'h0180, 4'b1101};
        vecs[6] = '{"dest_eq_ports", 8'h04, 8'h01, 9'h005, 1'b0, 16'h0401, 4'b1111};

        reset = 1'b1; start = 1'b0; destination = '0; data = '0; checkSum = '0;
        repeat (3) @(negedge clock);
        check("reset_cs_n",  int'(cs_n),  15);
        check("reset_sclk",  int'(sclk),  0);
        check("reset_mosi",  int'(mosi),  0);
        check("reset_busy",  int'(busy),  0);
        check("reset_done",  int'(done),  0);
        check("reset_error", int'(error), 0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run(vecs[i].dest, vecs[i].dat, vecs[i].chk, -1, -1, ek, dk, nd, ne, nr, bf, bl, fr, cs);
            check({vecs[i].name, "_busy_first"}, bf, 1);
            if (vecs[i].accept) begin
                check({vecs[i].name, "_done_cycle"}, dk, LAT);
                check({vecs[i].name, "_done_count"}, nd, 1);
                check({vecs[i].name, "_err_count"},  ne, 0);
                check({vecs[i].name, "_rises"},      nr, 16);
                check({vecs[i].name, "_frame"},      int'(fr), int'(vecs[i].frame));
                check({vecs[i].name, "_cs"},         int'(cs), int'(4'(~vecs[i].cs)));
                check({vecs[i].name, "_busy_last"},  bl, LAT);
            end else begin
                check({vecs[i].name, "_err_cycle"},  ek, 2);
                check({vecs[i].name, "_err_count"},  ne, 1);
                check({vecs[i].name, "_done_count"}, nd, 0);
                check({vecs[i].name, "_rises"},      nr, 0);
                check({vecs[i].name, "_cs"},         int'(cs), 0);
                check({vecs[i].name, "_busy_last"},  bl, 2);
            end
        end

        // A start during the frame must be neither accepted nor queued.
        run(8'h02, 8'h35, 9'h037, 20, -1, ek, dk, nd, ne, nr, bf, bl, fr, cs);
        check("busy_start_done_count", nd, 1);
        check("busy_start_done_cycle", dk, LAT);
        check("busy_start_frame",      int'(fr), 16'h0235);
        check("busy_start_cs",         int'(cs), 4'b0100);
        check("busy_start_busy_last",  bl, LAT);

        // Reset in cycle N+50 aborts the frame with no done pulse.
        run(8'h02, 8'h35, 9'h037, -1, 50, ek, dk, nd, ne, nr, bf, bl, fr, cs);
        check("abort_done_count", nd, 0);
        check("abort_busy_last",  bl, 50);
        run(8'h03, 8'hFF, 9'h102, -1, -1, ek, dk, nd, ne, nr, bf, bl, fr, cs);
        check("after_abort_done_cycle", dk, LAT);
        check("after_abort_frame",      int'(fr), 16'h03FF);
        check("after_abort_rises",      nr, 16);

        // Reset wins over a simultaneous start.
        @(negedge clock);
        reset = 1'b1; start = 1'b1; destination = 8'h01; data = 8'h01; checkSum = 9'h002;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        check("rst_vs_start_busy0", int'(busy), 0);
        @(negedge clock);
        check("rst_vs_start_busy1", int'(busy), 0);
        check("rst_vs_start_cs_n",  int'(cs_n), 15);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/route_spi_tx.md
ROUTE_SPI_TX -- requirements
Module: route_spi_tx

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, width of destination and data fields.
REQ-002 The block SHALL have parameter PORTS, default 4, number of SPI output ports.
REQ-003 The block SHALL have parameter CLK_DIV, default 4 (minimum 2), clock cycles per SCLK half-period.
REQ-004 clock  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to route the presented packet.
REQ-007 destination  input  SIZE  target port number.
REQ-008 data  input  SIZE  payload byte.
REQ-009 checkSum  input  SIZE+1  sender checksum.
REQ-010 sclk  output  1  SPI clock, mode 0.
REQ-011 mosi  output  1  SPI serial data.
REQ-012 cs_n  output  PORTS  active-low chip select, one bit per port.
REQ-013 busy  output  1  high from the cycle after an accepted start until the cycle after done or error.
REQ-014 done  output  1  one-cycle pulse: frame sent.
REQ-015 error  output  1  one-cycle pulse: packet rejected.

Function
REQ-016 The block SHALL latch destination, data and checkSum in the cycle start is sampled high while in IDLE; inputs are ignored at all other times.
REQ-017 A start arriving while busy is high SHALL be ignored and SHALL NOT be queued.
REQ-018 FSM states SHALL be IDLE, CHECK, SETUP, SHIFT, HOLD, DONE, ERR.
REQ-019 Transitions: IDLE->CHECK on start; CHECK->ERR or SETUP; SETUP->SHIFT after CLK_DIV cycles; SHIFT->HOLD after 32 half-periods; HOLD->DONE after CLK_DIV cycles; DONE and ERR->IDLE after 1 cycle.
REQ-020 In CHECK, the block SHALL compute destination+data as a (SIZE+1)-bit zero-extended sum with carry kept and no wrap beyond SIZE+1 bits.
REQ-021 CHECK SHALL go to ERR if the sum differs from checkSum, or if destination >= PORTS.
REQ-022 The frame SHALL be {destination, data}, 2*SIZE bits, MSB first.
REQ-023 In SETUP, cs_n[destination] SHALL be driven low, sclk low, and mosi set to frame bit 2*SIZE-1.
REQ-024 In SHIFT, sclk SHALL toggle every CLK_DIV cycles starting low->high; mosi SHALL change only on SCLK falling edges; exactly 2*SIZE rising edges SHALL occur.
REQ-025 In HOLD, sclk SHALL be low and cs_n still asserted; cs_n SHALL return to all-ones on entry to DONE.
REQ-026 For a start sampled in cycle N, done SHALL be high in cycle N+2+(4*SIZE+2)*CLK_DIV (N+138 at defaults); error SHALL be high in cycle N+2.
REQ-027 In ERR, no cs_n bit SHALL assert and sclk SHALL NOT toggle.
REQ-028 Outside SETUP, SHIFT and HOLD, cs_n SHALL be all ones, sclk 0 and mosi 0.

Reset
REQ-029 While reset is high, the FSM SHALL go to IDLE; cs_n all ones; sclk, mosi, busy, done and error 0; latched fields and counters 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame, with cs_n all ones in the cycle following the reset edge and no done pulse.
REQ-031 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-032 With macro ROUTE_CHECKSUM_EN defined, the checksum comparison of REQ-021 SHALL be performed.
REQ-033 Without ROUTE_CHECKSUM_EN, checkSum SHALL be ignored and only an out-of-range destination SHALL cause ERR; CHECK timing stays one cycle.

Structure
REQ-034 The FSM state enumeration and the frame-width constant SHALL reside in the shared package router_pkg.
REQ-035 SCLK half-period timing SHALL be a sub-module spi_clk_gen, providing enable, rise and fall strobes; the shifter and FSM stay in route_spi_tx.

Verification
REQ-036 dest=0x02, data=0x35, checkSum=0x037 -> cs_n=4'b1011 during frame, mosi shifts 0x0235 on 16 rising edges, done at N+138.
REQ-037 dest=0x02, data=0x35, checkSum=0x036 -> error at N+2, cs_n stays 4'hF, no sclk edge, no done (with ROUTE_CHECKSUM_EN); same packet is forwarded without it.
REQ-038 dest=0x05, valid checksum 0x03A -> error at N+2, no frame.
REQ-039 dest=0x03, data=0xFF, checkSum=0x102 (carry case) -> accepted, frame 0x03FF on cs_n[3].
REQ-040 Second start at N+20 during a frame -> ignored; exactly one done.
REQ-041 Reset at N+50 -> cs_n 4'hF and busy 0 at N+51, no done; a new start afterwards completes normally.
